// File: rtl/sram_ana_pipe.sv
// ----------------------------------------------------------------------------
// sram_ana_pipe
// Single-port SRAM whose control, address and data lines are analog-coded
// levels (one ANA_WIDTH-bit lane per logical bit). Every lane is thresholded
// to a bit. After reset a sequencer clears every word before the port accepts
// accesses. Read data travels through a RD_LATENCY-deep register chain and is
// presented as full-scale/zero lanes together with a one-cycle rvalid pulse.
//
// Optional feature macro: ANA_HYST_EN
//   undefined : single threshold, a lane is 1 when level > FULL_SCALE/2
//   defined   : hysteresis of +/-HYST_MARGIN around FULL_SCALE/2, with a
//               registered previous bit per lane (reset to 0)
//
// Ports
//   clk_a   in   clock, rising edge
//   rst_a   in   synchronous active-high reset
//   req_a   in   access request lane
//   we_a    in   write-enable lane (1 = write, 0 = read)
//   addr_a  in   ADDR_WIDTH address lanes, index = address bit
//   din_a   in   DATA_WIDTH write-data lanes, index = data bit
//   dout_a  out  DATA_WIDTH read-data lanes, each FULL_SCALE or 0
//   rvalid  out  one-cycle pulse when dout_a has just been updated
//   ready   out  high once the clear sequence is done and accesses are taken
// ----------------------------------------------------------------------------
module sram_ana_pipe #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int ANA_WIDTH   = 8,
   parameter int FULL_SCALE  = 255,
   parameter int RD_LATENCY  = 1,
   parameter int HYST_MARGIN = 32
) (
   input  logic                 clk_a,
   input  logic                 rst_a,
   input  logic [ANA_WIDTH-1:0] req_a,
   input  logic [ANA_WIDTH-1:0] we_a,
   input  logic [ANA_WIDTH-1:0] addr_a [ADDR_WIDTH],
   input  logic [ANA_WIDTH-1:0] din_a  [DATA_WIDTH],
   output logic [ANA_WIDTH-1:0] dout_a [DATA_WIDTH],
   output logic                 rvalid,
   output logic                 ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NLANE = 2 + ADDR_WIDTH + DATA_WIDTH;
   localparam int MID   = FULL_SCALE / 2;
   localparam logic [ANA_WIDTH-1:0] LVL_ONE = ANA_WIDTH'(FULL_SCALE);

   genvar gi;

   // Elaboration-time sanity check of the configuration.
   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 4 || HYST_MARGIN < 0) begin : g_param_err
         $error("sram_ana_pipe: RD_LATENCY must be 1..4 and HYST_MARGIN >= 0");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Lane decode. All input lanes are gathered into one list so a single
   // decoder instance per lane serves both build variants:
   //   [0] req, [1] we, [2 +: ADDR_WIDTH] addr, then DATA_WIDTH data lanes.
   // ------------------------------------------------------------------------
   logic [ANA_WIDTH-1:0] w_lvl [NLANE];
   logic [NLANE-1:0]     w_bit;

   assign w_lvl[0] = req_a;
   assign w_lvl[1] = we_a;

   generate
      for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_lane
         assign w_lvl[2 + gi] = addr_a[gi];
      end
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_din_lane
         assign w_lvl[2 + ADDR_WIDTH + gi] = din_a[gi];
      end
   endgenerate

`ifdef ANA_HYST_EN
   localparam int HYST_HI = MID + HYST_MARGIN;
   localparam int HYST_LO = MID - HYST_MARGIN;

   logic [NLANE-1:0] r_prev;

   // Inside the dead band the lane keeps the bit it decoded last cycle; the
   // decision itself is combinational so the current level acts immediately.
   generate
      for (gi = 0; gi < NLANE; gi++) begin : g_dec
         assign w_bit[gi] = (int'(w_lvl[gi]) >= HYST_HI) ? 1'b1 :
                            (int'(w_lvl[gi]) <= HYST_LO) ? 1'b0 : r_prev[gi];
      end
   endgenerate

   always_ff @(posedge clk_a) begin
      if (rst_a) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_bit;
      end
   end
`else
   generate
      for (gi = 0; gi < NLANE; gi++) begin : g_dec
         assign w_bit[gi] = (int'(w_lvl[gi]) > MID);
      end
   endgenerate
`endif

   logic                  w_req;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_din;

   assign w_req  = w_bit[0];
   assign w_we   = w_bit[1];
   assign w_addr = w_bit[2 +: ADDR_WIDTH];
   assign w_din  = w_bit[2 + ADDR_WIDTH +: DATA_WIDTH];

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   typedef enum logic {S_INIT, S_IDLE} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic [RD_LATENCY-1:0] r_pipe_vld;
   logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_rvalid;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic w_access;
   logic w_rd_issue;
   logic w_wr_issue;

   // Requests are only honoured once the clear sequence has finished.
   assign w_access   = (r_state == S_IDLE) && w_req;
   assign w_rd_issue = w_access && !w_we;
   assign w_wr_issue = w_access &&  w_we;

   // ------------------------------------------------------------------------
   // Memory write port, shared between the clear sequencer and user writes.
   // ------------------------------------------------------------------------
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_waddr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_waddr = r_clr_ptr;
      w_mem_wdata = '0;
      if (!rst_a) begin
         if (r_state == S_INIT) begin
            w_mem_we = 1'b1;
         end else if (w_wr_issue) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_addr;
            w_mem_wdata = w_din;
         end
      end
   end

   always_ff @(posedge clk_a) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   // Registered read (read-first) feeding the latency chain. The data stages
   // carry no reset: only the valid bits decide whether a value is used, and
   // those are flushed by reset.
   always_ff @(posedge clk_a) begin
      r_pipe_data[0] <= r_mem[w_addr];
      for (int k = 1; k < RD_LATENCY; k++) begin
         r_pipe_data[k] <= r_pipe_data[k-1];
      end
   end

   // ------------------------------------------------------------------------
   // FSM with registered outputs and read-valid chain
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_a) begin
      if (rst_a) begin
         r_state    <= S_INIT;
         r_clr_ptr  <= '0;
         r_pipe_vld <= '0;
         r_dout     <= '0;
         r_rvalid   <= 1'b0;
         r_ready    <= 1'b0;
      end else begin
         r_pipe_vld[0] <= w_rd_issue;
         for (int k = 1; k < RD_LATENCY; k++) begin
            r_pipe_vld[k] <= r_pipe_vld[k-1];
         end

         r_rvalid <= r_pipe_vld[RD_LATENCY-1];
         if (r_pipe_vld[RD_LATENCY-1]) begin
            r_dout <= r_pipe_data[RD_LATENCY-1];
         end

         case (r_state)
            S_INIT: begin
               r_clr_ptr <= r_clr_ptr + 1'b1;
               if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_INIT;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign rvalid = r_rvalid;
   assign ready  = r_ready;

   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_dout_lane
         assign dout_a[gi] = r_dout[gi] ? LVL_ONE : '0;
      end
   endgenerate

endmodule

// File: tb/tb_sram_ana_pipe.sv
// ----------------------------------------------------------------------------
// tb_sram_ana_pipe
// Three instances (RD_LATENCY 1, 2, 3) share one stimulus stream. A reference
// model (word array, per-cycle log of issued reads, ready counter) predicts
// ready, rvalid and dout for every instance after every clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_ana_pipe;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int AN    = 8;
   localparam int FS    = 255;
   localparam int HM    = 32;
   localparam int DEPTH = 16;
   localparam int NL    = 2 + AW + DW;
   localparam int MID   = FS / 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AN-1:0] req_l;
   logic [AN-1:0] we_l;
   logic [AN-1:0] addr_l [AW];
   logic [AN-1:0] din_l  [DW];
   logic [AN-1:0] dout1 [DW];
   logic [AN-1:0] dout2 [DW];
   logic [AN-1:0] dout3 [DW];
   logic          rv1, rv2, rv3;
   logic          rdy1, rdy2, rdy3;

   sram_ana_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ANA_WIDTH(AN), .FULL_SCALE(FS),
                   .RD_LATENCY(1), .HYST_MARGIN(HM)) dut1 (
      .clk_a(clk), .rst_a(rst), .req_a(req_l), .we_a(we_l), .addr_a(addr_l),
      .din_a(din_l), .dout_a(dout1), .rvalid(rv1), .ready(rdy1));

   sram_ana_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ANA_WIDTH(AN), .FULL_SCALE(FS),
                   .RD_LATENCY(2), .HYST_MARGIN(HM)) dut2 (
      .clk_a(clk), .rst_a(rst), .req_a(req_l), .we_a(we_l), .addr_a(addr_l),
      .din_a(din_l), .dout_a(dout2), .rvalid(rv2), .ready(rdy2));

   sram_ana_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ANA_WIDTH(AN), .FULL_SCALE(FS),
                   .RD_LATENCY(3), .HYST_MARGIN(HM)) dut3 (
      .clk_a(clk), .rst_a(rst), .req_a(req_l), .we_a(we_l), .addr_a(addr_l),
      .din_a(din_l), .dout_a(dout3), .rvalid(rv3), .ready(rdy3));

   // ---------------- reference model ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] issued [int];      // cycle of issue -> word read at that edge
   bit            m_ready = 1'b0;
   int            m_init  = 0;
   logic [DW-1:0] e_dout [3];
   bit            e_rv   [3];
`ifdef ANA_HYST_EN
   bit [NL-1:0]   m_prev = '0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [63:0] pk(input logic [AN-1:0] d [DW]);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) r[i*AN +: AN] = d[i];
      return r;
   endfunction

   function automatic logic [63:0] ex(input logic [DW-1:0] b);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) r[i*AN +: AN] = b[i] ? AN'(FS) : '0;
      return r;
   endfunction

   // Level for an intended bit: usually full scale / zero, sometimes a random
   // level clearly on the intended side of both the plain and hysteresis bands.
   function automatic logic [AN-1:0] lv(input bit b);
      if ($urandom_range(0, 3) == 0)
         return b ? AN'($urandom_range(MID + HM + 1, FS)) : AN'($urandom_range(0, MID - HM));
      return b ? AN'(FS) : '0;
   endfunction

   task automatic drive(input bit rq, input bit w, input int a, input int d);
      req_l = lv(rq);
      we_l  = lv(w);
      for (int i = 0; i < AW; i++) addr_l[i] = lv(a[i]);
      for (int i = 0; i < DW; i++) din_l[i]  = lv(d[i]);
   endtask

   // One clock: decode the driven levels, advance the model across the edge,
   // then compare all three instances.
   task automatic step();
      bit [NL-1:0]   b;
      int            lvl;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < NL; i++) begin
         if (i == 0)           lvl = int'(req_l);
         else if (i == 1)      lvl = int'(we_l);
         else if (i < 2 + AW)  lvl = int'(addr_l[i-2]);
         else                  lvl = int'(din_l[i-2-AW]);
`ifdef ANA_HYST_EN
         b[i] = (lvl >= MID + HM) ? 1'b1 : (lvl <= MID - HM) ? 1'b0 : m_prev[i];
`else
         b[i] = (lvl > MID);
`endif
      end
      a = b[2 +: AW];
      d = b[2 + AW +: DW];
      @(posedge clk);
      cyc++;
      if (rst) begin
         issued.delete();
         m_ready = 1'b0;
         m_init  = 0;
         for (int k = 0; k < 3; k++) begin e_rv[k] = 1'b0; e_dout[k] = '0; end
`ifdef ANA_HYST_EN
         m_prev = '0;
`endif
      end else begin
`ifdef ANA_HYST_EN
         m_prev = b;
`endif
         if (!m_ready) begin
            m_init++;
            if (m_init == DEPTH) begin
               m_ready = 1'b1;
               for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
         end else if (b[0]) begin
            if (b[1]) m_mem[a] = d;
            else      issued[cyc] = m_mem[a];
         end
         for (int k = 0; k < 3; k++) begin
            if (issued.exists(cyc - (k + 1))) begin
               e_rv[k]   = 1'b1;
               e_dout[k] = issued[cyc - (k + 1)];
            end else begin
               e_rv[k] = 1'b0;
            end
         end
      end
      #1;
      check("ready_l1", 64'(rdy1), 64'(m_ready));
      check("ready_l2", 64'(rdy2), 64'(m_ready));
      check("ready_l3", 64'(rdy3), 64'(m_ready));
      check("rvalid_l1", 64'(rv1), 64'(e_rv[0]));
      check("rvalid_l2", 64'(rv2), 64'(e_rv[1]));
      check("rvalid_l3", 64'(rv3), 64'(e_rv[2]));
      check("dout_l1", pk(dout1), ex(e_dout[0]));
      check("dout_l2", pk(dout2), ex(e_dout[1]));
      check("dout_l3", pk(dout3), ex(e_dout[2]));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0);

      // Reset, clear sequence (requests during INIT must be ignored), read all.
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
         step();
      end
      check("ready_after_clear", 64'(rdy1), 64'd1);
      for (int i = 0; i < DEPTH; i++) begin drive(1, 0, i, 0); step(); end
      drive(0, 0, 0, 0); step(); step(); step();

      // Write i to address i, then back-to-back reads.
      for (int i = 0; i < DEPTH; i++) begin drive(1, 1, i, i); step(); end
      for (int i = 0; i < DEPTH; i++) begin drive(1, 0, i, 0); step(); end
      drive(0, 1, 0, 0); step(); step(); step();

      // addr 5 = 0xA5, read, lanes checked explicitly on the latency-3 instance.
      drive(1, 1, 5, 8'hA5); step();
      drive(1, 0, 5, 0);     step();
      drive(0, 0, 0, 0);     step(); step(); step();
      check("tp3_rvalid_l3", 64'(rv3), 64'd1);
      check("tp3_lanes_l3", pk(dout3), 64'hFF00_FF00_00FF_00FF);
      step();

      // Read 7 (0x11) immediately followed by write 7 = 0xEE, then reread.
      drive(1, 1, 7, 8'h11); step();
      drive(1, 0, 7, 0);     step();
      drive(1, 1, 7, 8'hEE); step();
      drive(0, 0, 0, 0);     step();
      check("tp4_old_data_l2", pk(dout2), ex(8'h11));
      drive(1, 0, 7, 0);     step();
      drive(0, 0, 0, 0);     step(); step(); step();
      check("tp4_new_data_l2", pk(dout2), ex(8'hEE));

      // Reset one cycle after a read issue: in-flight read discarded.
      drive(1, 0, 5, 0); step();
      rst = 1'b1; drive(0, 0, 0, 0); step();
      rst = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) step();

      // Threshold levels: data lanes alternate 128/127.
      drive(1, 1, 3, 0);
      for (int i = 0; i < DW; i++) din_l[i] = (i % 2 == 0) ? 8'd128 : 8'd127;
      step();
      // Lane 0 walks 200 -> 130 -> 90 on three consecutive writes.
      drive(1, 1, 8, 0);  din_l[0] = 8'd200; step();
      drive(1, 1, 9, 0);  din_l[0] = 8'd130; step();
      drive(1, 1, 10, 0); din_l[0] = 8'd90;  step();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, (i == 0) ? 3 : 7 + i, 0);
         step();
      end
      drive(0, 0, 0, 0); step(); step(); step();
`ifndef ANA_HYST_EN
      check("thresh_128_127", pk(dout1), ex(8'h00));
`endif

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
         step();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
